// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer and the traffic controller:
// phase codes, timer state encoding and the phase-to-length selector.
package phase_timer_pkg;

    localparam logic [2:0] PH_IDLE       = 3'd0;
    localparam logic [2:0] PH_T1G_T2R    = 3'd1;
    localparam logic [2:0] PH_T1Y_T2R    = 3'd2;
    localparam logic [2:0] PH_T1R_T2R    = 3'd3;
    localparam logic [2:0] PH_T2G_T1R    = 3'd4;
    localparam logic [2:0] PH_T2Y_T1R    = 3'd5;
    localparam logic [2:0] PH_T2R_T1R    = 3'd6;
    localparam logic [2:0] PH_CHANGE_SEC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } timer_state_t;

    typedef enum logic [1:0] {
        SEL_GREEN  = 2'd0,
        SEL_YELLOW = 2'd1,
        SEL_ALLRED = 2'd2,
        SEL_NONE   = 2'd3
    } len_sel_t;

    // Which configured duration a phase uses; SEL_NONE marks a code that
    // cannot be loaded into the timer.
    function automatic len_sel_t len_sel(input logic [2:0] phase);
        len_sel_t sel;
        case (phase)
            PH_T1G_T2R, PH_T2G_T1R: sel = SEL_GREEN;
            PH_T1Y_T2R, PH_T2Y_T1R: sel = SEL_YELLOW;
            PH_T1R_T2R, PH_T2R_T1R: sel = SEL_ALLRED;
            default:                sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Countdown timer for traffic-light phases on the 1 Hz divided clock:
// loads a phase duration, counts it down, pulses expire and counts full cycles.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int CYC_W    = 8,
    parameter int WARN_SEC = 1
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       phase_i,
    input  logic             pause,
    input  logic [CNT_W-1:0] rg_len,
    input  logic [CNT_W-1:0] y_len,
    input  logic [CNT_W-1:0] rr_len,
    output logic [CNT_W-1:0] sec_cnt,
    output logic             expire,
    output logic             busy,
    output logic             warn,
    output logic [2:0]       phase_o,
    output logic [CYC_W-1:0] cycle_cnt
);

    timer_state_t     state_reg, state_next;
    logic [CNT_W-1:0] sec_reg, sec_next;
    logic             expire_reg, expire_next;
    logic [2:0]       phase_reg, phase_next;
    logic [CYC_W-1:0] cycle_reg, cycle_next;

    len_sel_t         sel;
    logic [CNT_W-1:0] load_len;
    logic             valid_start;

    always_comb begin
        sel      = len_sel(phase_i);
        load_len = '0;
        case (sel)
            SEL_GREEN:  load_len = rg_len;
            SEL_YELLOW: load_len = y_len;
            SEL_ALLRED: load_len = rr_len;
            default:    load_len = '0;
        endcase
        valid_start = start && (sel != SEL_NONE);
    end

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            sec_reg    <= '0;
            expire_reg <= 1'b0;
            phase_reg  <= PH_IDLE;
            cycle_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            sec_reg    <= sec_next;
            expire_reg <= expire_next;
            phase_reg  <= phase_next;
            cycle_reg  <= cycle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sec_next    = sec_reg;
        expire_next = 1'b0;
        phase_next  = phase_reg;
        cycle_next  = cycle_reg;

        if (valid_start) begin
            sec_next   = load_len;
            phase_next = phase_i;
            // A zero-length phase is over the moment it is loaded.
            if (load_len == '0) begin
                state_next  = ST_DONE;
                expire_next = 1'b1;
                if (phase_i == PH_T2R_T1R)
                    cycle_next = cycle_reg + CYC_W'(1);
            end else begin
                state_next = pause ? ST_HOLD : ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_HOLD;
                    end else if (sec_reg > CNT_W'(1)) begin
                        sec_next = sec_reg - CNT_W'(1);
                    end else begin
                        sec_next    = '0;
                        expire_next = 1'b1;
                        state_next  = ST_DONE;
                        if (phase_reg == PH_T2R_T1R)
                            cycle_next = cycle_reg + CYC_W'(1);
                    end
                end
                // Leaving HOLD spends one edge without decrementing so the
                // interrupted second is counted in full.
                ST_HOLD: begin
                    if (!pause)
                        state_next = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    assign sec_cnt   = sec_reg;
    assign expire    = expire_reg;
    assign phase_o   = phase_reg;
    assign cycle_cnt = cycle_reg;
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_HOLD);
    assign warn      = busy && (sec_reg >= CNT_W'(1)) && (sec_reg <= CNT_W'(WARN_SEC));

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Countdown timer for the traffic-light phases, one stage upstream of the traffic controller FSM. It runs on the divided 1 Hz clock.
- Loads the duration of the requested phase (green, yellow or all-red) and counts it down once per div_clk.
- Flags phase expiry with a one-cycle pulse.
- Supplies the seconds value for the LED display and a last-second warning.
- Counts completed full light cycles for diagnostics.

Parameters:
CNT_W, 4, width of seconds count and of all phase lengths
CYC_W, 8, width of completed-cycle counter
WARN_SEC, 1, warn asserted while remaining seconds is 1..WARN_SEC

Ports:
div_clk  in  1  divided 1 Hz clock; all inputs synchronous to it
rst  in  1  asynchronous, active-low reset
start  in  1  load phase_i duration and begin counting
phase_i  in  3  phase code: 1 T1G_T2R, 2 T1Y_T2R, 3 T1R_T2R, 4 T2G_T1R, 5 T2Y_T1R, 6 T2R_T1R
pause  in  1  freeze count (high while in configuration mode)
rg_len  in  CNT_W  green duration, seconds
y_len  in  CNT_W  yellow duration, seconds
rr_len  in  CNT_W  all-red duration, seconds
sec_cnt  out  CNT_W  remaining seconds
expire  out  1  one-cycle pulse when the count reaches 0
busy  out  1  high in RUN or HOLD
warn  out  1  busy and 1 <= sec_cnt <= WARN_SEC
phase_o  out  3  phase currently loaded (0 when none)
cycle_cnt  out  CYC_W  number of completed phase-6 expiries

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE.
  - sec_cnt = 0, expire = 0, phase_o = 0, cycle_cnt = 0.
  - busy and warn therefore read 0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registers or decoded from registers; there are no combinational paths from inputs to outputs.
- Length select is combinational on phase_i:
  - 1 or 4 -> rg_len
  - 2 or 5 -> y_len
  - 3 or 6 -> rr_len
  - 0 or 7 -> invalid
- Valid start, in any state, has the highest priority:
  - On that edge: sec_cnt <= selected length, phase_o <= phase_i.
  - Next state is HOLD if pause = 1, otherwise RUN.
  - If the selected length is 0: state <= DONE and expire <= 1 on the same edge; the pause input is ignored in this case.
- Invalid start (phase_i = 0 or 7): ignored, with no change to any register.
- Length inputs are sampled only on a valid start. Changing them mid-phase does not affect the running count.
- RUN, no start:
  - pause = 1 -> HOLD, sec_cnt unchanged.
  - sec_cnt > 1 -> sec_cnt decrements by 1.
  - sec_cnt = 1 -> sec_cnt <= 0, expire <= 1, state <= DONE.
- HOLD, no start: stays while pause = 1. When pause = 0 -> RUN with no decrement on that edge, so a paused second is never lost.
- DONE:
  - expire <= 0 on the next edge; expire is never high for two consecutive cycles unless a new zero-length start occurs.
  - sec_cnt stays 0 and phase_o is held until the next valid start.
- IDLE: holds until a valid start.
- Cycle counter: cycle_cnt increments by 1 on each edge where expire is set with phase_o = 6 (or phase_i = 6 for a zero-length load). It wraps from 2^CYC_W-1 to 0.
- Latency:
  - Load-to-expire is exactly L div_clk edges for length L >= 1, excluding edges spent in HOLD.
  - A zero-length phase expires on the load edge itself.
- Reset mid-count aborts immediately to the reset values; there is no pending expire.

Decomposition:
- Shared package holds:
  - the phase code constants 0..7, identical to the controller FSM encoding (0 IDLE, 1-6 as above, 7 CHANGE_SEC);
  - the timer state encoding (IDLE=0, RUN=1, HOLD=2, DONE=3);
  - a length-select function, shared with the controller.
- No sub-module: a single flat block.

Test Plan:
1. Reset, then start with phase_i=1, rg_len=5 -> sec_cnt reads 5,4,3,2,1,0 on successive edges. expire is high only on the edge where sec_cnt becomes 0. warn is high while sec_cnt=1. busy drops with DONE.
2. Start with phase_i=2, y_len=0 -> DONE and expire=1 on the load edge; expire=0 on the next edge; sec_cnt stays 0.
3. rr_len=4, phase 3 running at sec_cnt=3; pause high for 3 edges, then low -> sec_cnt holds 3 for 3 edges, stays 3 on the release edge, then 2,1,0.
4. rg_len=9, phase 4 at sec_cnt=6; restart with phase_i=5, y_len=2 -> sec_cnt=2 and phase_o=5 on the next edge; no expire is emitted for the aborted phase.
5. Run 256 phase-6 expiries with rr_len=1 -> cycle_cnt reaches 255 and then wraps to 0. A start with phase_i=7 mid-run -> no register changes.
6. rst low at sec_cnt=3 in RUN -> immediately sec_cnt=0, busy=0, expire=0, cycle_cnt=0.
